// File: rtl/uart_ctrl_fifo.sv
// uart_ctrl_fifo: 16x-oversampled UART (RX/TX engines) with RX/TX FIFOs, show-ahead host strobes, RX->TX echo.
// Latency: RX byte enters the FIFO at the mid-stop sample; TX frame starts on the first tick after the FIFO is non-empty.
// Backpressure: tx_full blocks host writes (forced in echo mode); a byte arriving on a full RX FIFO is dropped and flags overrun.
// Build option: define UART_PARITY_EN to add an even parity bit between data and stop (TX insert, RX check).
module uart_ctrl_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic                          tx,
  input  logic                          echo_en,
  input  logic                          tx_wr,
  input  logic [DATA_BITS-1:0]          tx_wdata,
  output logic                          tx_full,
  output logic                          tx_busy,
  output logic                          tx_done,
  input  logic                          rx_rd,
  output logic [DATA_BITS-1:0]          rx_rdata,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_done,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err,
  input  logic                          err_clr
);
  localparam int BAUD_DIV = CLK_HZ / (BAUD * 16);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DIV_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------- baud generator and input synchroniser ----------------
  logic [CW-1:0] baud_cnt;
  logic          tick;
  logic          rx_meta, rx_s;
  logic          echo_q;

  assign tick = (baud_cnt == DIV_LAST);

  // free-running oversample counter, tick on wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + CW'(1);
  end

  // two-flop synchroniser for the asynchronous rx pin (idle high)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // echo enable is registered so mode changes land on a clean cycle boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) echo_q <= 1'b0;
    else      echo_q <= echo_en;
  end

  // ---------------- FIFOs and echo path ----------------
  logic                        rx_push, rx_pop, rx_ff_full, rx_ff_empty;
  logic [DATA_BITS-1:0]        rx_head, rx_shift;
  logic                        tx_ff_wr, tx_pop, tx_ff_full, tx_ff_empty;
  logic [DATA_BITS-1:0]        tx_ff_wdata, tx_head;
  logic [$clog2(FIFO_DEPTH):0] tx_cnt_unused;
  logic                        echo_move;

  assign echo_move   = echo_q && !rx_ff_empty && !tx_ff_full;
  assign rx_pop      = echo_q ? echo_move : rx_rd;
  assign tx_ff_wr    = echo_q ? echo_move : tx_wr;
  assign tx_ff_wdata = echo_q ? rx_head : tx_wdata;
  assign tx_full     = echo_q || tx_ff_full;
  assign rx_empty    = rx_ff_empty;
  assign rx_rdata    = rx_ff_empty ? '0 : rx_head;

  uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr(rx_push), .wdata(rx_shift), .rd(rx_pop),
    .rdata(rx_head), .full(rx_ff_full), .empty(rx_ff_empty), .count(rx_count)
  );

  uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr(tx_ff_wr), .wdata(tx_ff_wdata), .rd(tx_pop),
    .rdata(tx_head), .full(tx_ff_full), .empty(tx_ff_empty), .count(tx_cnt_unused)
  );

  // ---------------- RX engine ----------------
  state_t        rx_state, rx_state_nxt;
  logic [3:0]    rx_tcnt;
  logic [BW-1:0] rx_bitn;
  logic          rx_par;
  logic          rx_stop_smp, rx_par_bad, set_ferr, set_perr, set_ovr;

  // RX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= S_IDLE;
    else      rx_state <= rx_state_nxt;
  end

  // RX next state: start qualified at half-bit, then mid-bit samples every 16 ticks
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      S_IDLE:  if (tick && !rx_s) rx_state_nxt = S_START;
      S_START: if (tick && rx_tcnt == 4'd7) rx_state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (tick && rx_tcnt == 4'd15 && rx_bitn == BIT_LAST)
                 rx_state_nxt = PARITY_ON ? S_PAR : S_STOP;
      S_PAR:   if (tick && rx_tcnt == 4'd15) rx_state_nxt = S_STOP;
      S_STOP:  if (tick && rx_tcnt == 4'd15) rx_state_nxt = S_IDLE;
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  // RX outputs: stop-bit verdict decides push or which error to raise
  always_comb begin
    rx_stop_smp = (rx_state == S_STOP) && tick && (rx_tcnt == 4'd15);
    rx_par_bad  = PARITY_ON && ((^rx_shift) != rx_par);
    set_ferr    = rx_stop_smp && !rx_s;
    set_perr    = rx_stop_smp && rx_s && rx_par_bad;
    set_ovr     = rx_stop_smp && rx_s && !rx_par_bad && rx_ff_full;
    rx_push     = rx_stop_smp && rx_s && !rx_par_bad && !rx_ff_full;
  end

  assign rx_done = rx_push;

  // RX tick/bit counters and LSB-first shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_tcnt  <= '0;
      rx_bitn  <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else if (rx_state == S_IDLE) begin
      rx_tcnt <= '0;
      rx_bitn <= '0;
    end else if (tick) begin
      if (rx_state == S_START && rx_tcnt == 4'd7) rx_tcnt <= '0;
      else                                        rx_tcnt <= rx_tcnt + 4'd1;
      if (rx_state == S_DATA && rx_tcnt == 4'd15) begin
        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
        rx_bitn  <= rx_bitn + BW'(1);
      end
      if (rx_state == S_PAR && rx_tcnt == 4'd15) rx_par <= rx_s;
    end
  end

  // sticky error flags; a same-cycle clear wins over a set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else if (err_clr) begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (set_ferr) frame_err  <= 1'b1;
      if (set_ovr)  overrun    <= 1'b1;
      if (set_perr) parity_err <= 1'b1;
    end
  end

  // ---------------- TX engine ----------------
  state_t               tx_state, tx_state_nxt;
  logic [3:0]           tx_tcnt;
  logic [BW-1:0]        tx_bitn;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par, tx_q, tx_end;

  // TX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= S_IDLE;
    else      tx_state <= tx_state_nxt;
  end

  // TX next state: 16 ticks per bit; chain straight into the next frame when data waits
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      S_IDLE:  if (tick && !tx_ff_empty) tx_state_nxt = S_START;
      S_START: if (tick && tx_tcnt == 4'd15) tx_state_nxt = S_DATA;
      S_DATA:  if (tick && tx_tcnt == 4'd15 && tx_bitn == BIT_LAST)
                 tx_state_nxt = PARITY_ON ? S_PAR : S_STOP;
      S_PAR:   if (tick && tx_tcnt == 4'd15) tx_state_nxt = S_STOP;
      S_STOP:  if (tick && tx_tcnt == 4'd15) tx_state_nxt = tx_ff_empty ? S_IDLE : S_START;
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  // TX outputs: pop on frame launch, done in the last stop-bit cycle
  always_comb begin
    tx_end  = (tx_state == S_STOP) && tick && (tx_tcnt == 4'd15);
    tx_pop  = ((tx_state == S_IDLE) && tick && !tx_ff_empty) || (tx_end && !tx_ff_empty);
    tx_done = tx_end;
    tx_busy = (tx_state != S_IDLE);
  end

  assign tx = tx_q;

  // TX shifter and registered line driver (glitch-free pin)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_tcnt  <= '0;
      tx_bitn  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
    end else if (tx_pop) begin
      tx_shift <= tx_head;
      tx_par   <= ^tx_head;
      tx_tcnt  <= '0;
      tx_bitn  <= '0;
      tx_q     <= 1'b0;
    end else if (tx_state != S_IDLE && tick) begin
      tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_tcnt == 4'd15) begin
        case (tx_state)
          S_START: tx_q <= tx_shift[0];
          S_DATA: begin
            if (tx_bitn == BIT_LAST) begin
              tx_q <= PARITY_ON ? tx_par : 1'b1;
            end else begin
              tx_shift <= tx_shift >> 1;
              tx_q     <= tx_shift[1];
              tx_bitn  <= tx_bitn + BW'(1);
            end
          end
          default: tx_q <= 1'b1;
        endcase
      end
    end
  end
endmodule

// uart_fifo: generic show-ahead FIFO with registered full/empty flags.
// Latency: written data visible at the head the cycle after the write.
// Backpressure: write when full and read when empty are silently ignored.
module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;
  logic [AW:0]   count_nxt;

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = mem[rd_ptr];

  // occupancy after this cycle's accepted operations
  always_comb count_nxt = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally at power-of-two depth; flags registered from next count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_V);
      empty <= (count_nxt == '0);
    end
  end
endmodule

// File: tb/tb_uart_ctrl_fifo.sv
`timescale 1ns/1ps
module tb_uart_ctrl_fifo;
  localparam int BIT_CLK = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       echo_en = 1'b0;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_wdata = 8'h00;
  logic       rx_rd = 1'b0;
  logic       err_clr = 1'b0;
  logic       tx, tx_full, tx_busy, tx_done, rx_empty, rx_done;
  logic       frame_err, overrun, parity_err;
  logic [7:0] rx_rdata;
  logic [2:0] rx_count;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int         frame_start[$];
  int cyc = 0, tx_done_cnt = 0, rx_done_cnt = 0, frame_cnt = 0, tx_low_cnt = 0;
  bit         mon_busy = 1'b0;
  int         mon_cnt = 0;
  logic [9:0] mon_bits = '0;

  always #5 clk = ~clk;

  uart_ctrl_fifo #(.CLK_HZ(1_600_000), .BAUD(10_000), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .echo_en(echo_en),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_count(rx_count), .rx_done(rx_done),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err), .err_clr(err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: decodes tx frames against exp_tx, checks host reads against exp_rx, counts pulses
  always @(negedge clk) begin
    cyc++;
    if (tx_done) tx_done_cnt++;
    if (rx_done) rx_done_cnt++;
    if (rst && tx !== 1'b1) tx_low_cnt++;
    if (rst && rx_rd && !rx_empty && !echo_en) begin
      if (exp_rx.size() == 0) begin
        total++; bad++;
        $display("FAIL rx_read: got %0h, no byte expected", rx_rdata);
      end else begin
        check("rx_read", rx_rdata, exp_rx.pop_front());
      end
    end
    if (!rst) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt = 0;
        frame_start.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % BIT_CLK == BIT_CLK / 2) begin
        mon_bits[(mon_cnt - BIT_CLK / 2) / BIT_CLK] = tx;
        if (mon_cnt == BIT_CLK / 2 + 9 * BIT_CLK) begin
          mon_busy = 1'b0;
          frame_cnt++;
          check("tx_start_bit", mon_bits[0], 1'b0);
          check("tx_stop_bit", mon_bits[9], 1'b1);
          if (exp_tx.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_frame: got %0h, no frame expected", mon_bits[8:1]);
          end else begin
            check("tx_byte", mon_bits[8:1], exp_tx.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    step(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic host_read();
    rx_rd = 1'b1;
    step(1);
    rx_rd = 1'b0;
    step(1);
  endtask

  task automatic host_write(input logic [7:0] d);
    tx_wr = 1'b1;
    tx_wdata = d;
    step(1);
    tx_wr = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    step(1);
  endtask

  initial begin
    int base, fbase;
    // reset state
    step(3);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_rx_done", rx_done, 1'b0);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_rx_count", rx_count, 3'd0);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_rx_rdata", rx_rdata, 8'h00);
    rst = 1'b1;
    step(5);

    // host TX 0xA5
    base = tx_done_cnt;
    exp_tx.push_back(8'hA5);
    host_write(8'hA5);
    step(15);
    check("tx_busy_mid", tx_busy, 1'b1);
    for (int i = 0; i < 3000 && tx_done_cnt == base; i++) step(1);
    step(50);
    check("tx_done_once", tx_done_cnt - base, 1);
    check("tx_busy_fell", tx_busy, 1'b0);
    check("tx_frames_a5", frame_cnt, 1);

    // RX 0x3C then a 60-clk glitch
    base = rx_done_cnt;
    exp_rx.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    step(100);
    rx = 1'b0;
    step(60);
    rx = 1'b1;
    step(300);
    check("rx_count_3c", rx_count, 3'd1);
    check("rx_head_3c", rx_rdata, 8'h3C);
    check("rx_done_3c", rx_done_cnt - base, 1);
    check("glitch_no_ferr", frame_err, 1'b0);
    host_read();
    check("rx_empty_after_read", rx_empty, 1'b1);

    // five bytes into a 4-deep FIFO
    base = rx_done_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) exp_rx.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    step(20);
    check("ovr_count", rx_count, 3'd4);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_head", rx_rdata, 8'h01);
    check("ovr_rx_done", rx_done_cnt - base, 4);
    check("ovr_no_ferr", frame_err, 1'b0);
    pulse_clr();
    check("ovr_cleared", overrun, 1'b0);
    repeat (4) host_read();
    check("ovr_drained", rx_empty, 1'b1);

    // bad stop bit
    base = rx_done_cnt;
    send_frame(8'h55, 1'b0);
    step(300);
    check("ferr_set", frame_err, 1'b1);
    check("ferr_rx_empty", rx_empty, 1'b1);
    check("ferr_no_rx_done", rx_done_cnt - base, 0);
    pulse_clr();
    check("ferr_cleared", frame_err, 1'b0);

    // echo mode
    echo_en = 1'b1;
    step(2);
    check("echo_tx_full", tx_full, 1'b1);
    base = frame_start.size();
    fbase = frame_cnt;
    host_write(8'h99);
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(2000);
    check("echo_frames", frame_cnt - fbase, 2);
    check("echo_starts", frame_start.size() - base, 2);
    if (frame_start.size() >= base + 2)
      check("echo_no_gap", frame_start[base+1] - frame_start[base], 10 * BIT_CLK);
    check("echo_rx_empty", rx_empty, 1'b1);
    check("echo_tx_drained", exp_tx.size(), 0);
    echo_en = 1'b0;
    step(2);

    // reset mid TX frame with bytes queued
    host_write(8'hAA);
    host_write(8'hBB);
    host_write(8'hCC);
    exp_tx.push_back(8'hAA);
    step(500);
    check("mid_tx_busy", tx_busy, 1'b1);
    rst = 1'b0;
    #1;
    check("arst_tx_high", tx, 1'b1);
    check("arst_tx_busy", tx_busy, 1'b0);
    check("arst_rx_empty", rx_empty, 1'b1);
    check("arst_tx_full", tx_full, 1'b0);
    step(5);
    rst = 1'b1;
    step(1);
    exp_tx.delete();
    base = tx_low_cnt;
    fbase = frame_cnt;
    step(2500);
    check("post_rst_no_frame", frame_cnt - fbase, 0);
    check("post_rst_tx_idle", tx_low_cnt - base, 0);
    check("post_rst_busy", tx_busy, 1'b0);
    check("end_rx_queue", exp_rx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
